// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO write-side arbiter and the FIFO.
//   arb_state_e    : arbiter FSM state
//   FIFO_WIDTH     : default data word width (both blocks must agree)
//   DEF_N_REQ      : default requester count
//   DEF_MAX_BURST  : default burst cap (words per grant)
//   OWNER_W/CNT_W  : index / burst-counter widths for the defaults
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int FIFO_WIDTH    = 1;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 8;
  localparam int OWNER_W       = $clog2(DEF_N_REQ);
  localparam int CNT_W         = $clog2(DEF_MAX_BURST + 1);

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker (masked priority encoder).
//   i_req   : request vector
//   i_ptr   : index at which the upward scan starts (wraps modulo N)
//   o_valid : some request bit is set
//   o_idx   : first set bit at or after i_ptr
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int IDX_W = $clog2(DEF_N_REQ)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  int w_j;

  // Scan offsets 0..N-1 from i_ptr; the first hit latches and blocks later ones.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_valid && i_req[w_j]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// N_REQ producers, granting bursts of up to MAX_BURST words.
//   clk, reset_n   : clock, async active-low reset
//   req/last/data  : per-requester request, end-of-burst mark, packed words
//   fifo_full      : FIFO full flag (stalls the owner, never ends a burst)
//   gnt            : registered one-hot grant
//   ack            : per-requester "word consumed this cycle"
//   fifo_write_en  : FIFO write strobe
//   fifo_data_in   : owner's word (0 when not writing)
//   busy           : in BURST
//   owner          : current or last grantee
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int N_REQ     = DEF_N_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          last,
  input  logic [N_REQ*WIDTH-1:0]    data,
  input  logic                      fifo_full,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic                      fifo_write_en,
  output logic [WIDTH-1:0]          fifo_data_in,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e        r_state;
  logic [N_REQ-1:0]  r_gnt;
  logic [OW-1:0]     r_owner;
  logic [OW-1:0]     r_rr_ptr;
  logic [CW-1:0]     r_burst_cnt;

  logic              w_pick_vld;
  logic [OW-1:0]     w_pick_idx;
  logic              w_busy;
  logic              w_req_own;
  logic              w_xfer;
  logic              w_we;
  logic              w_exit;
  logic [OW-1:0]     w_owner_nxt;

  rr_pick #(.N(N_REQ), .IDX_W(OW)) u_pick (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  assign w_busy    = (r_state == BURST);
  assign w_req_own = req[r_owner];
  assign w_xfer    = w_req_own & ~fifo_full;
  assign w_we      = w_busy & w_xfer;

  // A stalled (full) cycle with req held never ends the burst; dropping req does.
  assign w_exit = ~w_req_own
                | (w_xfer & last[r_owner])
                | (w_xfer & (r_burst_cnt == CW'(MAX_BURST - 1)));

  assign w_owner_nxt = (r_owner == OW'(N_REQ - 1)) ? '0 : r_owner + OW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_state     <= BURST;
            r_gnt       <= N_REQ'(1) << w_pick_idx;
            r_owner     <= w_pick_idx;
            r_burst_cnt <= '0;
          end
        end
        BURST: begin
          if (w_xfer) r_burst_cnt <= r_burst_cnt + CW'(1);
          // Always return through IDLE so the next pick sees the advanced pointer.
          if (w_exit) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= w_owner_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign busy          = w_busy;
  assign owner         = r_owner;
  assign fifo_write_en = w_we;
  assign fifo_data_in  = w_we ? data[int'(r_owner)*WIDTH +: WIDTH] : '0;
  // gnt is one-hot on owner throughout BURST, so it doubles as the ack mask.
  assign ack           = {N_REQ{w_we}} & r_gnt;

endmodule
